// File: rtl/ob_sorted_table.sv
// ----------------------------------------------------------------------------
// ob_sorted_table
//   Price/time-priority store for one side of the order book. Up to N entries
//   are kept sorted so slot 0 always holds the winning order. Commands
//   (insert, pop-top, cancel-by-UID) arrive on a valid/ready port; each one
//   produces a response that is held until rsp_accept.
//
//   Ports
//     clk, rst      clock, synchronous active-high reset
//     cmd_vld       command valid
//     cmd_op        00 insert, 01 pop-top, 10 cancel, 11 reserved
//     cmd_entry     entry to insert; cancel uses .uid only
//     cmd_rdy       command accepted this cycle when high
//     rsp_vld       response valid, held until rsp_accept
//     rsp_accept    response consumed
//     rsp_status    S_Okay / S_Reject / S_ErrRejectTableFull / S_BadPop
//     rsp_entry     popped or cancelled entry, '0 otherwise
//     top_vld       table not empty
//     top_entry     slot 0 (INIT value when empty)
//     count         number of valid entries
// ----------------------------------------------------------------------------

package bcd_pkg;
   // Six BCD digits (XXXX.XX); BCD ordering equals unsigned magnitude ordering.
   typedef logic [23:0] price_t;
endpackage

package ob_pkg;
   typedef struct packed {
      logic [31:0]      uid;
      bcd_pkg::price_t  price;
      logic [15:0]      quantity;
   } table_t;

   typedef enum logic [1:0] {
      S_Okay               = 2'd0,
      S_Reject             = 2'd1,
      S_ErrRejectTableFull = 2'd2,
      S_BadPop             = 2'd3
   } status_t;

   typedef enum logic [1:0] {
      OP_INSERT = 2'd0,
      OP_POP    = 2'd1,
      OP_CANCEL = 2'd2,
      OP_RSVD   = 2'd3
   } op_t;

   // Empty slots hold the worst possible price for their side.
   localparam table_t TABLE_BID_INIT = '{uid: 32'h0, price: 24'h000000, quantity: 16'h0};
   localparam table_t TABLE_ASK_INIT = '{uid: 32'h0, price: 24'h999999, quantity: 16'h0};
endpackage

module ob_sorted_table #(
   parameter int unsigned N      = 16,
   parameter bit          IS_BID = 1'b1,
   parameter int unsigned CNT_W  = $clog2(N + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_vld,
   input  logic [1:0]           cmd_op,
   input  ob_pkg::table_t       cmd_entry,
   output logic                 cmd_rdy,
   output logic                 rsp_vld,
   input  logic                 rsp_accept,
   output ob_pkg::status_t      rsp_status,
   output ob_pkg::table_t       rsp_entry,
   output logic                 top_vld,
   output ob_pkg::table_t       top_entry,
   output logic [CNT_W-1:0]     count
);

   localparam int unsigned IDX_W = $clog2(N);
   localparam ob_pkg::table_t INIT = IS_BID ? ob_pkg::TABLE_BID_INIT : ob_pkg::TABLE_ASK_INIT;

   typedef enum logic {ST_IDLE, ST_RSP} state_t;

   state_t           state;
   ob_pkg::table_t   slots     [N];
   ob_pkg::table_t   nxt_slots [N];
   logic [CNT_W-1:0] nxt_count;
   ob_pkg::status_t  nxt_status;
   ob_pkg::table_t   nxt_entry;

   logic [IDX_W-1:0] ins_idx;
   logic             ins_found;
   logic [IDX_W-1:0] can_idx;
   logic             can_hit;
   logic [IDX_W-1:0] rm_idx;
   logic             remove;

   // a strictly better than b for this side
   function automatic logic better(input bcd_pkg::price_t a, input bcd_pkg::price_t b);
      return IS_BID ? (a > b) : (a < b);
   endfunction

   assign cmd_rdy   = (state == ST_IDLE) && !rst;
   assign top_entry = slots[0];
   assign top_vld   = (count != '0);

   // Insert lands at the first empty slot or the first strictly worse price,
   // so equal prices stay in arrival order.
   always_comb begin
      ins_idx   = '0;
      ins_found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!ins_found && (i >= 32'(count) || better(cmd_entry.price, slots[i].price))) begin
            ins_idx   = IDX_W'(i);
            ins_found = 1'b1;
         end
      end
   end

   always_comb begin
      can_idx = '0;
      can_hit = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!can_hit && i < 32'(count) && slots[i].uid == cmd_entry.uid) begin
            can_idx = IDX_W'(i);
            can_hit = 1'b1;
         end
      end
   end

   always_comb begin
      nxt_slots  = slots;
      nxt_count  = count;
      nxt_status = ob_pkg::S_Okay;
      nxt_entry  = '0;
      rm_idx     = '0;
      remove     = 1'b0;
      case (ob_pkg::op_t'(cmd_op))
         ob_pkg::OP_INSERT: begin
            if (cmd_entry.uid == '1 || cmd_entry.quantity == '0) begin
               nxt_status = ob_pkg::S_Reject;
            end else if (count == CNT_W'(N)) begin
               nxt_status = ob_pkg::S_ErrRejectTableFull;
            end else begin
               for (int unsigned i = 1; i < N; i++) begin
                  if (IDX_W'(i) > ins_idx) nxt_slots[i] = slots[i-1];
               end
               nxt_slots[ins_idx] = cmd_entry;
               nxt_count          = count + CNT_W'(1);
            end
         end
         ob_pkg::OP_POP: begin
            if (count == '0) begin
               nxt_status = ob_pkg::S_BadPop;
            end else begin
               nxt_entry = slots[0];
               remove    = 1'b1;
            end
         end
         ob_pkg::OP_CANCEL: begin
            if (!can_hit) begin
               nxt_status = ob_pkg::S_Reject;
            end else begin
               nxt_entry = slots[can_idx];
               rm_idx    = can_idx;
               remove    = 1'b1;
            end
         end
         default: nxt_status = ob_pkg::S_Reject;
      endcase
      // Pop is a cancel of slot 0; both close the gap and refill the tail with INIT.
      if (remove) begin
         for (int unsigned i = 0; i < N - 1; i++) begin
            if (IDX_W'(i) >= rm_idx) nxt_slots[i] = slots[i+1];
         end
         nxt_slots[N-1] = INIT;
         nxt_count      = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < N; i++) slots[i] <= INIT;
         count      <= '0;
         state      <= ST_IDLE;
         rsp_vld    <= 1'b0;
         rsp_status <= ob_pkg::S_Okay;
         rsp_entry  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_vld) begin
                  slots      <= nxt_slots;
                  count      <= nxt_count;
                  rsp_status <= nxt_status;
                  rsp_entry  <= nxt_entry;
                  rsp_vld    <= 1'b1;
                  state      <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (rsp_accept) begin
                  rsp_vld <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
